shift_reg_univ: RTL and testbench

//   Parametrised universal register: WIDTH flip-flops with async active-low clear,

---
 rtl/shift_reg_univ_if.sv | 29 ++
 rtl/shift_reg_univ.sv | 97 +++++++++
 tb/tb_shift_reg_univ.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_univ_if.sv
// Control, data and status bundle for the universal shift register.
// The master side drives controls and data; the slave side is the register itself.
interface shift_reg_univ_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             en;
   logic [2:0]       mode;
   logic [WIDTH-1:0] d;
   logic             sin_r;
   logic             sin_l;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qb;
   logic             sout_r;
   logic             sout_l;
   logic [CW-1:0]    cnt;
   logic             done;

   modport master (
      output en, mode, d, sin_r, sin_l,
      input  q, qb, sout_r, sout_l, cnt, done
   );

   modport slave (
      input  en, mode, d, sin_r, sin_l,
      output q, qb, sout_r, sout_l, cnt, done
   );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: hold/shift/rotate/load/sync clear/set, with a
// saturating shift counter and a one-cycle done pulse for serializer framing.
module shift_reg_univ #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic             clk,
   input logic             clear,
   shift_reg_univ_if.slave bus
);
   localparam int            CW      = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_SHR  = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_ROR  = 3'b011,
      MODE_ROL  = 3'b100,
      MODE_LOAD = 3'b101,
      MODE_CLR  = 3'b110,
      MODE_SET  = 3'b111
   } mode_e;

   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             counting;

   // NOTE: every variable gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      data_d   = data_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      counting = 1'b0;
      if (bus.en) begin
         case (mode_e'(bus.mode))
            MODE_HOLD: ;
            MODE_SHR: begin
               data_d   = {bus.sin_r, data_q[WIDTH-1:1]};
               counting = 1'b1;
            end
            MODE_SHL: begin
               data_d   = {data_q[WIDTH-2:0], bus.sin_l};
               counting = 1'b1;
            end
            MODE_ROR: begin
               data_d   = {data_q[0], data_q[WIDTH-1:1]};
               counting = 1'b1;
            end
            MODE_ROL: begin
               data_d   = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
               counting = 1'b1;
            end
            MODE_LOAD: begin
               data_d = bus.d;
               cnt_d  = '0;
            end
            MODE_CLR: begin
               data_d = '0;
               cnt_d  = '0;
            end
            MODE_SET: begin
               data_d = '1;
               cnt_d  = '0;
            end
         endcase
      end
      // Saturated counter keeps shifting data but never re-fires done.
      if (counting && (cnt_q != CNT_MAX)) begin
         cnt_d  = cnt_q + CW'(1);
         done_d = (cnt_q == CNT_MAX - CW'(1));
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         data_q <= RESET_VAL;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign bus.q      = data_q;
   assign bus.qb     = ~data_q;
   assign bus.sout_r = data_q[0];
   assign bus.sout_l = data_q[WIDTH-1];
   assign bus.cnt    = cnt_q;
   assign bus.done   = done_q;
endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ: stimulus pushes expected state from an
// arithmetic reference model, a monitor pops and compares after every edge.
module tb_shift_reg_univ;
   localparam int W    = 8;
   localparam int MASK = (1 << W) - 1;

   typedef struct {
      int q;
      int cnt;
      bit done;
   } exp_t;

   logic clk;
   logic clear;
   int   pass_cnt;
   int   total_cnt;
   exp_t sb[$];

   int m_q;
   int m_cnt;
   bit m_done;

   shift_reg_univ_if #(.WIDTH(W)) bus ();

   shift_reg_univ #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
      .clk  (clk),
      .clear(clear),
      .bus  (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
      else
         pass_cnt++;
   endtask

   // Reference model: register as an integer, counter as a plain count of
   // shift/rotate ops capped at W, done when that count first hits W.
   task automatic model_step(input bit en_i, input int mode_i, input int d_i,
                             input bit sr, input bit sl);
      int prev;
      prev   = m_cnt;
      m_done = 1'b0;
      if (!en_i) return;
      case (mode_i)
         1: m_q = (m_q >> 1) | (int'(sr) << (W - 1));
         2: m_q = ((m_q << 1) | int'(sl)) & MASK;
         3: m_q = (m_q >> 1) | ((m_q % 2) << (W - 1));
         4: m_q = ((m_q << 1) | (m_q >> (W - 1))) & MASK;
         5: m_q = d_i & MASK;
         6: m_q = 0;
         7: m_q = MASK;
         default: ;
      endcase
      if (mode_i >= 1 && mode_i <= 4) begin
         if (m_cnt < W) m_cnt = m_cnt + 1;
         m_done = (prev < W) && (m_cnt == W);
      end else if (mode_i >= 5) begin
         m_cnt = 0;
      end
   endtask

   task automatic op(input bit en_i, input int mode_i, input int d_i,
                     input bit sr, input bit sl);
      @(negedge clk);
      bus.en    = en_i;
      bus.mode  = 3'(mode_i);
      bus.d     = 8'(d_i);
      bus.sin_r = sr;
      bus.sin_l = sl;
      model_step(en_i, mode_i, d_i, sr, sl);
      sb.push_back('{q: m_q, cnt: m_cnt, done: m_done});
   endtask

   // Short clear pulse that does not span a clock edge; effect must be immediate.
   task automatic clear_pulse();
      @(posedge clk);
      #2;
      clear = 1'b0;
      #1;
      check("async_clear_q", 32'(bus.q), 32'h00);
      check("async_clear_qb", 32'(bus.qb), 32'hFF);
      check("async_clear_cnt", 32'(bus.cnt), 32'd0);
      check("async_clear_done", 32'(bus.done), 32'd0);
      m_q    = 0;
      m_cnt  = 0;
      m_done = 1'b0;
      #1;
      clear = 1'b1;
   endtask

   // Monitor: every edge presents a new register state.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("q", 32'(bus.q), 32'(e.q));
            check("qb", 32'(bus.qb), 32'(e.q ^ MASK));
            check("sout_r", 32'(bus.sout_r), 32'(e.q % 2));
            check("sout_l", 32'(bus.sout_l), 32'(e.q >> (W - 1)));
            check("cnt", 32'(bus.cnt), 32'(e.cnt));
            check("done", 32'(bus.done), 32'(e.done));
         end
      end
   end

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      clear     = 1'b1;
      bus.en    = 1'b0;
      bus.mode  = 3'd0;
      bus.d     = 8'h00;
      bus.sin_r = 1'b0;
      bus.sin_l = 1'b0;
      m_q       = 0;
      m_cnt     = 0;
      m_done    = 1'b0;

      // Asynchronous clear before any clock edge.
      #3;
      clear = 1'b0;
      #1;
      check("reset_q", 32'(bus.q), 32'h00);
      check("reset_qb", 32'(bus.qb), 32'hFF);
      check("reset_cnt", 32'(bus.cnt), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      @(posedge clk);
      #2;
      clear = 1'b1;

      // LOAD A5 then eight SHR with zero fill; done after the eighth.
      op(1, 5, 'hA5, 0, 0);
      repeat (8) op(1, 1, 0, 0, 0);

      // LOAD 81, rotate left three times, right once; counting continues.
      op(1, 5, 'h81, 0, 0);
      repeat (3) op(1, 4, 0, 0, 0);
      op(1, 3, 0, 0, 0);

      // Reach saturation, shift past it, then disabled LOAD changes nothing.
      repeat (4) op(1, 2, 0, 0, 1);
      repeat (2) op(1, 2, 0, 0, 1);
      op(0, 5, 'h55, 0, 0);
      op(0, 1, 0, 1, 1);

      // LOAD replaces the edge that would have completed the count.
      op(1, 5, 'h3C, 0, 0);
      repeat (7) op(1, 1, 0, 1, 0);
      op(1, 5, 'h0F, 0, 0);
      op(1, 7, 0, 0, 0);
      op(1, 6, 0, 0, 0);
      op(1, 0, 0, 1, 1);

      // Clear mid-sequence aborts the count.
      op(1, 5, 'h5A, 0, 0);
      repeat (4) op(1, 2, 0, 0, 0);
      clear_pulse();
      repeat (4) op(1, 2, 0, 0, 1);
      repeat (4) op(1, 2, 0, 0, 1);

      // Randomized traffic biased toward counting ops.
      for (int i = 0; i < 400; i++) begin
         int r;
         int md;
         if ($urandom_range(59) == 0) begin
            clear_pulse();
         end else begin
            r  = int'($urandom_range(99));
            md = (r < 70) ? int'(1 + $urandom_range(3)) : int'($urandom_range(7));
            op(($urandom_range(9) != 0), md, int'($urandom_range(255)),
               1'($urandom_range(1)), 1'($urandom_range(1)));
         end
      end

      // Drain the scoreboard within a bounded number of edges.
      for (int i = 0; i < 4 && sb.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
